// File: rtl/lzss_window_copy_if.sv
`default_nettype none
// ============================================================================
// Module      : lzss_window_copy_if
// Description : Token input and byte output handshake bundle for
//               lzss_window_copy. master = token producer / byte consumer,
//               slave = the window-copy stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface lzss_window_copy_if #(
    parameter int OFF_W = 10,
    parameter int LEN_W = 4
);
    logic             tok_valid;
    logic             tok_ready;
    logic             tok_is_lit;
    logic [7:0]       tok_lit;
    logic [OFF_W-1:0] tok_offset;
    logic [LEN_W-1:0] tok_len;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_byte;

    modport master (
        output tok_valid, tok_is_lit, tok_lit, tok_offset, tok_len,
        input  tok_ready,
        input  out_valid, out_byte,
        output out_ready
    );

    modport slave (
        input  tok_valid, tok_is_lit, tok_lit, tok_offset, tok_len,
        output tok_ready,
        output out_valid, out_byte,
        input  out_ready
    );
endinterface
`default_nettype wire

// File: rtl/lzss_window_copy.sv
`default_nettype none
// ============================================================================
// Module      : lzss_window_copy
// Description : LZSS output stage. Turns literal / back-reference tokens into
//               a byte stream through a 2^OFF_W byte history window, one byte
//               per cycle under valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module lzss_window_copy #(
    parameter int OFF_W = 10,
    parameter int LEN_W = 4
) (
    input  wire logic          clk,
    input  wire logic          rstn,        // active-high asynchronous reset
    lzss_window_copy_if.slave  bus,
    output logic [31:0]        out_count,
    output logic               err
);

    localparam logic [OFF_W:0] c_WIN = {1'b1, {OFF_W{1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } state_t;

    state_t           r_state;
    logic [OFF_W-1:0] r_wr_ptr;
    logic [OFF_W-1:0] r_rd_ptr;
    logic [OFF_W:0]   r_fill;
    logic [LEN_W-1:0] r_rem;
    logic             r_zero_fill;
    logic             r_out_valid;
    logic [7:0]       r_out_byte;
    logic [31:0]      r_out_count;
    logic             r_err;
    logic [7:0]       r_hist [0:(1<<OFF_W)-1];

    state_t           w_state_nxt;
    logic [OFF_W-1:0] w_rd_ptr_nxt;
    logic [LEN_W-1:0] w_rem_nxt;
    logic             w_zero_fill_nxt;
    logic             w_err_set;
    logic             w_emit;
    logic [7:0]       w_emit_byte;
    logic             w_slot_free;
    logic             w_tok_ready;
    logic             w_accept;
    logic [OFF_W:0]   w_dist;

    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_tok_ready = (r_state == ST_IDLE) && w_slot_free && !rstn;
    assign w_accept    = bus.tok_valid && w_tok_ready;
    assign w_dist      = {1'b0, bus.tok_offset} + (OFF_W+1)'(1);

    assign bus.tok_ready = w_tok_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_byte  = r_out_byte;
    assign out_count     = r_out_count;
    assign err           = r_err;

    // Next-state and emit decision for the token/copy sequencer
    always_comb begin
        w_state_nxt     = r_state;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_rem_nxt       = r_rem;
        w_zero_fill_nxt = r_zero_fill;
        w_err_set       = 1'b0;
        w_emit          = 1'b0;
        w_emit_byte     = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (bus.tok_is_lit) begin
                        w_emit      = 1'b1;
                        w_emit_byte = bus.tok_lit;
                    end else if (bus.tok_len == '0) begin
                        w_err_set = 1'b1;
                    end else begin
                        // Distance reaching before the first byte ever written
                        // is unrecoverable: flag it and emit zeros instead.
                        w_rd_ptr_nxt    = r_wr_ptr - bus.tok_offset - OFF_W'(1);
                        w_rem_nxt       = bus.tok_len;
                        w_zero_fill_nxt = (w_dist > r_fill);
                        w_err_set       = (w_dist > r_fill);
                        w_state_nxt     = ST_COPY;
                    end
                end
            end
            ST_COPY: begin
                if (w_slot_free) begin
                    // A byte written last edge is already visible here, so
                    // overlapping copies need no bypass path.
                    w_emit       = 1'b1;
                    w_emit_byte  = r_zero_fill ? 8'h00 : r_hist[r_rd_ptr];
                    w_rd_ptr_nxt = r_rd_ptr + OFF_W'(1);
                    w_rem_nxt    = r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer state, output register, pointers and counters
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_rem       <= '0;
            r_zero_fill <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_byte  <= 8'h00;
            r_out_count <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_rem       <= w_rem_nxt;
            r_zero_fill <= w_zero_fill_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_byte  <= w_emit_byte;
                r_wr_ptr    <= r_wr_ptr + OFF_W'(1);
                r_out_count <= r_out_count + 32'd1;
                if (r_fill != c_WIN) begin
                    r_fill <= r_fill + (OFF_W+1)'(1);
                end
            end else if (w_slot_free) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // History window: plain RAM, contents intentionally not reset
    always_ff @(posedge clk) begin
        if (w_emit) begin
            r_hist[r_wr_ptr] <= w_emit_byte;
        end
    end

endmodule
`default_nettype wire
